// File: rtl/aes_sub_bytes_if.sv
// Valid/ready stream bundle for the SubBytes pipeline: one input word with its
// mode bit, one output word carrying the same mode bit.
interface aes_sub_bytes_if #(
  parameter int LANES = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               in_inv;
  logic [8*LANES-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_inv;
  logic [8*LANES-1:0] out_data;

  modport master (
    output in_valid, in_inv, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_inv
  );

  modport slave (
    input  in_valid, in_inv, in_data, out_ready,
    output in_ready, out_valid, out_data, out_inv
  );
endinterface

// File: rtl/aes_sub_bytes_pipe.sv
// Two-stage AES SubBytes / InvSubBytes unit: stage 1 holds the raw word,
// stage 2 holds the substituted word and drives the output directly.
module aes_sub_bytes_pipe #(
  parameter int LANES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  output logic            busy,
  aes_sub_bytes_if.slave  bus
);

  // Byte x of each table sits at bits [2047-8x -: 8]; first row is most significant.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_fwd(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] sub_inv(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

  logic [8*LANES-1:0] s1_data;
  logic               s1_inv;
  logic               s1_valid;
  logic [8*LANES-1:0] s2_data;
  logic               s2_inv;
  logic               s2_valid;
  logic [8*LANES-1:0] sub_data;
  logic               s1_adv;
  logic               s2_adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign sub_data[8*i +: 8] = s1_inv ? sub_inv(s1_data[8*i +: 8])
                                       : sub_fwd(s1_data[8*i +: 8]);
  end

  // Stage 1 may load in the same cycle stage 2 frees up, so ready looks at out_ready.
  assign bus.in_ready = ~s1_valid | ~s2_valid | bus.out_ready;
  assign s2_adv       = s1_valid & (~s2_valid | bus.out_ready);
  assign s1_adv       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_inv   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= 1'b1;
      s1_data  <= bus.in_data;
      s1_inv   <= bus.in_inv;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_inv   <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      s2_data  <= sub_data;
      s2_inv   <= s1_inv;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_inv   = s2_inv;
  assign busy          = s1_valid | s2_valid;

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// Self-checking bench for aes_sub_bytes_pipe: a GF(2^8)-derived S-box model feeds
// a scoreboard queue, plus per-scenario inline checks.
module tb_aes_sub_bytes_pipe;
  localparam int LANES = 16;
  localparam int W = 8 * LANES;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  aes_sub_bytes_if #(.LANES(LANES)) bus ();

  aes_sub_bytes_pipe #(.LANES(LANES)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         inv;
  } exp_t;

  int           n_checks = 0;
  int           n_fail = 0;
  int           cycle = 0;
  logic [7:0]   sbox_m [256];
  logic [7:0]   inv_m [256];
  exp_t         sb_q [$];
  logic [W-1:0] cap_q [$];
  exp_t         mon_e;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse followed by the affine map, then invert the table.
  task automatic build_model();
    logic [7:0] b;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sbox_m[x] = s;
    end
    for (int x = 0; x < 256; x++) inv_m[sbox_m[x]] = 8'(x);
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = inv ? inv_m[d[8*i +: 8]] : sbox_m[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL scoreboard_extra: got data=%h inv=%b, required no output", bus.out_data, bus.out_inv);
        end else begin
          mon_e = sb_q.pop_front();
          if (bus.out_data !== mon_e.data || bus.out_inv !== mon_e.inv) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_word: got %h/%b, required %h/%b", bus.out_data, bus.out_inv, mon_e.data, mon_e.inv);
          end
        end
        cap_q.push_back(bus.out_data);
      end
      if (bus.in_valid && bus.in_ready) begin
        mon_e.data = model(bus.in_data, bus.in_inv);
        mon_e.inv  = bus.in_inv;
        sb_q.push_back(mon_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the word until it is accepted; in_valid stays high on return.
  task automatic send(input logic [W-1:0] d, input logic inv);
    bit acc;
    int guard;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_inv   = inv;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      guard++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL send_timeout: got in_ready=0 for 200 cycles, required acceptance");
    end
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((sb_q.size() != 0 || busy !== 1'b0) && guard < 50) begin
      tick();
      guard++;
    end
    n_checks++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drain_%s: got pending=%0d busy=%b, required 0/0", name, sb_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_inv = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    n_checks++;
    if (bus.out_data !== '0) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h, required 0", bus.out_data); end
    n_checks++;
    if (bus.out_inv !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_inv: got %b, required 0", bus.out_inv); end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
  endtask

  task automatic test_single(input logic inv);
    logic [7:0]   pa [4];
    logic [7:0]   pb [4];
    logic [W-1:0] d;
    logic [W-1:0] e;
    pa = '{8'h00, 8'h53, 8'hff, 8'h01};
    pb = '{8'h63, 8'hed, 8'h16, 8'h7c};
    for (int i = 0; i < LANES; i++) begin
      d[8*i +: 8] = inv ? pb[i % 4] : pa[i % 4];
      e[8*i +: 8] = inv ? pa[i % 4] : pb[i % 4];
    end
    bus.out_ready = 1'b1;
    send(d, inv);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_stage1: got out_valid=%b busy=%b, required 0/1", bus.out_valid, busy);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== e || bus.out_inv !== inv) begin
      n_fail++;
      $display("[TB] FAIL single_result: got v=%b %h/%b, required v=1 %h/%b", bus.out_valid, bus.out_data, bus.out_inv, e, inv);
    end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] orig [16];
    logic [W-1:0] fwd_res [16];
    int start;
    for (int w = 0; w < 16; w++)
      for (int i = 0; i < LANES; i++) orig[w][8*i +: 8] = 8'(w * 16 + i);
    for (int pass = 0; pass < 2; pass++) begin
      cap_q.delete();
      bus.out_ready = 1'b1;
      start = cycle;
      for (int w = 0; w < 16; w++) send(pass == 0 ? orig[w] : fwd_res[w], 1'(pass));
      bus.in_valid = 1'b0;
      n_checks++;
      if (cycle - start != 16) begin
        n_fail++;
        $display("[TB] FAIL stream_cycles_%0d: got %0d cycles, required 16", pass, cycle - start);
      end
      wait_drain("stream");
      n_checks++;
      if (cap_q.size() != 16) begin
        n_fail++;
        $display("[TB] FAIL stream_count_%0d: got %0d words, required 16", pass, cap_q.size());
      end else if (pass == 0) begin
        for (int w = 0; w < 16; w++) fwd_res[w] = cap_q[w];
      end else begin
        for (int w = 0; w < 16; w++) begin
          n_checks++;
          if (cap_q[w] !== orig[w]) begin
            n_fail++;
            $display("[TB] FAIL round_trip_%0d: got %h, required %h", w, cap_q[w], orig[w]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] wd [4];
    for (int i = 0; i < 4; i++) wd[i] = rand_word();
    cap_q.delete();
    bus.out_ready = 1'b0;
    send(wd[0], 1'b0);
    send(wd[1], 1'b1);
    bus.in_data = wd[2];
    bus.in_inv  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready_%0d: got %b, required 0", c, bus.in_ready); end
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== model(wd[0], 1'b0)) begin
        n_fail++;
        $display("[TB] FAIL bp_hold_%0d: got v=%b %h, required v=1 %h", c, bus.out_valid, bus.out_data, model(wd[0], 1'b0));
      end
      tick();
    end
    n_checks++;
    if (sb_q.size() != 2) begin n_fail++; $display("[TB] FAIL bp_absorbed: got %0d words, required 2", sb_q.size()); end
    bus.out_ready = 1'b1;
    send(wd[2], 1'b0);
    send(wd[3], 1'b1);
    wait_drain("backpressure");
    n_checks++;
    if (cap_q.size() != 4) begin
      n_fail++;
      $display("[TB] FAIL bp_count: got %0d words, required 4", cap_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (cap_q[i] !== model(wd[i], 1'(i % 2))) begin
          n_fail++;
          $display("[TB] FAIL bp_order_%0d: got %h, required %h", i, cap_q[i], model(wd[i], 1'(i % 2)));
        end
      end
    end
  endtask

  task automatic test_mode_alternation();
    bit done;
    done = 1'b0;
    cap_q.delete();
    fork
      begin
        for (int i = 0; i < 40; i++) send(rand_word(), 1'(i % 2));
        bus.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    wait_drain("mode_alt");
    n_checks++;
    if (cap_q.size() != 40) begin n_fail++; $display("[TB] FAIL mode_alt_count: got %0d, required 40", cap_q.size()); end
  endtask

  task automatic test_flush();
    logic [W-1:0] w3;
    w3 = rand_word();
    bus.out_ready = 1'b0;
    send(rand_word(), 1'b0);
    send(rand_word(), 1'b1);
    bus.in_data = rand_word();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_full: got out_valid=%b busy=%b, required 0/0", bus.out_valid, busy);
    end
    send(rand_word(), 1'b0);
    bus.in_valid = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data = rand_word();
    flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_in_ready: got %b, required 1", bus.in_ready); end
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_input: got out_valid=%b busy=%b, required 0/0", bus.out_valid, busy);
    end
    bus.out_ready = 1'b1;
    send(w3, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== model(w3, 1'b1) || bus.out_inv !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL flush_after: got v=%b %h/%b, required v=1 %h/1", bus.out_valid, bus.out_data, bus.out_inv, model(w3, 1'b1));
    end
    wait_drain("flush");
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] w2;
    w2 = rand_word();
    bus.out_ready = 1'b0;
    send(rand_word(), 1'b0);
    send(rand_word(), 1'b1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL rst_async: got v=%b busy=%b %h, required 0/0/0", bus.out_valid, busy, bus.out_data);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b, required 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    send(w2, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== model(w2, 1'b0)) begin
      n_fail++;
      $display("[TB] FAIL rst_after: got v=%b %h, required v=1 %h", bus.out_valid, bus.out_data, model(w2, 1'b0));
    end
    wait_drain("reset");
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_inv = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    build_model();
    test_reset();
    test_single(1'b0);
    test_single(1'b1);
    test_back_to_back();
    test_backpressure();
    test_mode_alternation();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
